fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
//  Serial transmitter on the read side of the async FIFO, in the clk_rd domain.
//  Pops bytes from the first-word-fall-through FIFO and sends each one as an 8N1-style
//  UART frame (optional parity, 1 or 2 stop bits) on O_txd, LSB first.
//  Provides the FIFO-drain half of the byte-stream-to-serial path.
// PARAMETERS
//  CLK_FREQ    50_000_000  clk_rd frequency, Hz
//  BAUD_RATE   115_200     line rate, bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, must be >= 2
//  DATAWIDTH   8           data bits per frame, matches FIFO word width
//  PARITY_EN   0           1 = insert parity bit after data
//  PARITY_ODD  0           0 = even parity, 1 = odd parity (PARITY_EN=1 only)
//  STOP_BITS   1           1 or 2
// PORTS
//  clk_rd        in   1          clock (single clock domain, FIFO read clock)
//  rrst_n        in   1          asynchronous, active-low reset
//  I_enable      in   1          1 = allowed to start new frames
//  I_empty       in   1          FIFO empty flag
//  I_data_in     in   DATAWIDTH  FIFO head word, valid whenever I_empty=0
//  O_rden        out  1          one-cycle FIFO pop strobe
//  O_txd         out  1          serial line, idle high
//  O_busy        out  1          1 while a frame is in progress
//  O_frame_done  out  1          one-cycle pulse at end of last stop bit
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, O_txd=1, O_rden=0, O_busy=0, O_frame_done=0,
//    counters and shift register cleared. Reset mid-frame aborts; no partial pop.
//  O_rden is combinational: (state==IDLE) & I_enable & ~I_empty; never high outside IDLE.
//  On a clk_rd edge with O_rden=1: shift reg <= I_data_in, parity computed from it,
//    state -> START, baud counter <= 0. Exactly one pop per frame.
//  FSM: IDLE -> START -> DATA (DATAWIDTH bits) -> [PARITY if PARITY_EN] -> STOP (STOP_BITS) -> IDLE.
//  Each bit holds O_txd for exactly CLKS_PER_BIT cycles. Baud counter 0..CLKS_PER_BIT-1 wraps;
//    bit advances on wrap. Width: $clog2(CLKS_PER_BIT). Bit index width $clog2(DATAWIDTH).
//  O_txd registered: START=0, DATA=shift[0] (shift right per bit), PARITY=^data ^ PARITY_ODD,
//    STOP=1, IDLE=1. First start-bit cycle is the cycle after the pop.
//  Frame length = (1+DATAWIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
//  O_frame_done pulses on the last cycle of the final stop bit; state is IDLE next cycle.
//  Back-to-back: with data waiting, the next pop happens in the first IDLE cycle, so the
//    line idle gap between frames is exactly 1 clk_rd cycle (stop bit + 1 cycle).
//  O_busy = (state != IDLE).
//  I_enable low: no new pop; a frame already in progress always completes.
//  I_empty rising mid-frame: no effect until IDLE.
//  I_data_in is sampled only on the pop edge; later changes are ignored.
// STRUCTURE
//  uart_pkg: FSM state encodings (IDLE/START/DATA/PARITY/STOP) and default
//    CLK_FREQ/BAUD_RATE constants, shared with the future uart_rx.
//  Sub-module uart_baud_gen: counter 0..CLKS_PER_BIT-1 with sync clear and a one-cycle
//    tick on wrap, reused by the receiver.
//  Top: FSM, shift register, parity, output registers.
// TESTING (CLK_FREQ=40_000_000, BAUD_RATE=10_000_000 -> CLKS_PER_BIT=4)
//  1 Reset, I_empty=1 -> O_txd=1, O_rden=0, O_busy=0, O_frame_done=0 indefinitely.
//  2 FIFO holds 0xA5, I_enable=1 -> one O_rden pulse; O_txd bits 0,1,0,1,0,0,1,0,1,1,
//    4 clks each (40 clks); O_frame_done on clk 40; O_busy high for those 40 clks.
//  3 FIFO holds 0x00 then 0xFF -> two pops; the second pop is exactly 1 clk after the first
//    frame's O_frame_done; line idle between frames for 1 clk.
//  4 PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1, frame 44 clks;
//    with PARITY_ODD=1 -> parity bit 0.
//  5 rrst_n low during data bit 3 -> O_txd=1 and O_busy=0 same cycle; after release with
//    I_empty=0, a new frame starts with a fresh pop.
//  6 I_enable=0 with data waiting -> no pop for 100 clks; I_enable dropped mid-frame ->
//    frame completes, no further pop.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default clock/line rates and the
// bit-period helper. Used by the transmitter and the upcoming receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned DEFAULT_CLK_FREQ  = 50_000_000;
    localparam int unsigned DEFAULT_BAUD_RATE = 115_200;

    // Clock cycles per serial bit; callers must keep the result >= 2.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, with a synchronous clear.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   clr_i   synchronous clear, holds the count at 0
//   cnt_o   current count within the bit period
//   tick_o  high during the last cycle of each bit period (count == CLKS_PER_BIT-1)
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clr_i,
    output logic [$clog2(CLKS_PER_BIT)-1:0] cnt_o,
    output logic                            tick_o
);

    localparam int unsigned    CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q;

    // Next count: wrap at the end of the bit period, or restart on clear.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    // Tick is registered from the next count so it lines up with cnt_q == CNT_MAX.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == CNT_MAX);
        end
    end

    assign cnt_o  = cnt_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a first-word-fall-through FIFO in the read clock domain.
// Each popped word goes out as start bit, DATAWIDTH data bits LSB first, optional
// parity bit and STOP_BITS stop bits.
// Ports:
//   clk_rd        read-side clock
//   rrst_n        asynchronous active-low reset
//   I_enable      allow new frames to start
//   I_empty       FIFO empty flag
//   I_data_in     FIFO head word, valid while I_empty is low
//   O_rden        combinational one-cycle pop strobe
//   O_txd         serial line, idle high
//   O_busy        frame in progress
//   O_frame_done  one-cycle pulse on the last cycle of the final stop bit
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int unsigned DATAWIDTH  = 8,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk_rd,
    input  logic                 rrst_n,
    input  logic                 I_enable,
    input  logic                 I_empty,
    input  logic [DATAWIDTH-1:0] I_data_in,
    output logic                 O_rden,
    output logic                 O_txd,
    output logic                 O_busy,
    output logic                 O_frame_done
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W        = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

    uart_state_e          state_q;
    logic [DATAWIDTH-1:0] shift_q;
    logic                 par_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic                 txd_q;
    logic                 busy_q;
    logic                 done_q;

    logic [CNT_W-1:0]     baud_cnt;
    logic                 baud_tick;
    logic                 baud_clr;
    logic                 last_stop;
    logic                 done_pre;

    // Counter parks at 0 while idle so the start bit always gets a full period.
    assign baud_clr = (state_q == ST_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk_i (clk_rd),
        .rst_ni(rrst_n),
        .clr_i (baud_clr),
        .cnt_o (baud_cnt),
        .tick_o(baud_tick)
    );

    // Pop is suppressed while reset is held so an aborted frame never drains a word.
    assign O_rden = rrst_n & (state_q == ST_IDLE) & I_enable & ~I_empty;

    assign last_stop = (bit_idx_q == IDX_W'(STOP_BITS - 1));
    // One cycle early so the registered pulse lands on the final stop-bit cycle.
    assign done_pre  = (state_q == ST_STOP) && last_stop &&
                       (baud_cnt == CNT_W'(CLKS_PER_BIT - 2));

    // Frame sequencer, shift register and line driver.
    always_ff @(posedge clk_rd or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= done_pre;
            if (O_rden) begin
                state_q   <= ST_START;
                shift_q   <= I_data_in;
                par_q     <= (^I_data_in) ^ 1'(PARITY_ODD);
                bit_idx_q <= '0;
                txd_q     <= 1'b0;
                busy_q    <= 1'b1;
            end else if (baud_tick) begin
                unique case (state_q)
                    ST_START: begin
                        state_q   <= ST_DATA;
                        bit_idx_q <= '0;
                        txd_q     <= shift_q[0];
                    end
                    ST_DATA: begin
                        if (bit_idx_q == IDX_W'(DATAWIDTH - 1)) begin
                            bit_idx_q <= '0;
                            if (PARITY_EN != 0) begin
                                state_q <= ST_PARITY;
                                txd_q   <= par_q;
                            end else begin
                                state_q <= ST_STOP;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                            shift_q   <= shift_q >> 1;
                            txd_q     <= shift_q[1];
                        end
                    end
                    ST_PARITY: begin
                        state_q   <= ST_STOP;
                        bit_idx_q <= '0;
                        txd_q     <= 1'b1;
                    end
                    ST_STOP: begin
                        if (last_stop) begin
                            state_q   <= ST_IDLE;
                            bit_idx_q <= '0;
                            busy_q    <= 1'b0;
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign O_txd        = txd_q;
    assign O_busy       = busy_q;
    assign O_frame_done = done_q;

endmodule
